// File: rtl/rom_loader.sv
// Framed byte-stream loader for the ROM programming port (edit/unit/code/send).
// Frame: A5, length N (0 = 256), N code bytes, checksum (sum of code bytes mod 256).
module rom_loader #(
   parameter logic [7:0] BASE         = 8'h00,
   parameter int         SETUP_CYCLES = 2,
   parameter int         SEND_CYCLES  = 4,
   parameter int         CLR_CYCLES   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       abort,
   output logic       edit,
   output logic [7:0] unit,
   output logic [7:0] code,
   output logic       send,
   output logic       rstROM,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEN   = 3'd1;
   localparam logic [2:0] S_CLEAR = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_SETUP = 3'd4;
   localparam logic [2:0] S_SEND  = 3'd5;
   localparam logic [2:0] S_HOLD  = 3'd6;
   localparam logic [2:0] S_CHECK = 3'd7;

   localparam int TW = 16;
   // Timers count down from (cycles-1) and exit on the edge where they read zero.
   localparam logic [TW-1:0] SETUP_LD = TW'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
   localparam logic [TW-1:0] SEND_LD  = TW'((SEND_CYCLES  > 0) ? SEND_CYCLES  - 1 : 0);
   localparam logic [TW-1:0] CLR_LD   = TW'((CLR_CYCLES   > 0) ? CLR_CYCLES   - 1 : 0);

   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [8:0]    cnt_q, cnt_d;
   logic [7:0]    unit_q, unit_d;
   logic [7:0]    code_q, code_d;
   logic [7:0]    sum_q, sum_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          edit_q, edit_d;
   logic          send_q, send_d;
   logic          rstrom_q, rstrom_d;
   logic          busy_q, busy_d;
   logic          ready_en_q;
   logic          xfer;
   logic          finish_write;

   assign in_ready = ready_en_q &&
                     (state_q == S_IDLE || state_q == S_LEN ||
                      state_q == S_DATA || state_q == S_CHECK);
   assign xfer = in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      cnt_d        = cnt_q;
      unit_d       = unit_q;
      code_d       = code_q;
      sum_d        = sum_q;
      err_d        = err_q;
      done_d       = 1'b0;
      finish_write = 1'b0;

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (xfer && in_data == 8'hA5) begin
                  err_d   = 1'b0;
                  sum_d   = 8'h00;
                  state_d = S_LEN;
               end
            end
            S_LEN: begin
               if (xfer) begin
                  cnt_d  = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                  unit_d = BASE;
                  if (CLR_CYCLES > 0) begin
                     state_d = S_CLEAR;
                     timer_d = CLR_LD;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
            S_CLEAR: begin
               if (timer_q == '0) state_d = S_DATA;
               else               timer_d = timer_q - TW'(1);
            end
            S_DATA: begin
               if (xfer) begin
                  code_d = in_data;
                  sum_d  = sum_q + in_data;
                  if (SETUP_CYCLES > 0) begin
                     state_d = S_SETUP;
                     timer_d = SETUP_LD;
                  end else begin
                     state_d = S_SEND;
                     timer_d = SEND_LD;
                  end
               end
            end
            S_SETUP: begin
               if (timer_q == '0) begin
                  state_d = S_SEND;
                  timer_d = SEND_LD;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            S_SEND: begin
               if (timer_q == '0) begin
                  if (SETUP_CYCLES > 0) begin
                     state_d = S_HOLD;
                     timer_d = SETUP_LD;
                  end else begin
                     finish_write = 1'b1;
                  end
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            S_HOLD: begin
               if (timer_q == '0) finish_write = 1'b1;
               else               timer_d = timer_q - TW'(1);
            end
            S_CHECK: begin
               if (xfer) begin
                  if (in_data == sum_q) done_d = 1'b1;
                  else                  err_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase

         // Address advances only after the hold window, so unit never moves under send.
         if (finish_write) begin
            unit_d  = unit_q + 8'd1;
            cnt_d   = cnt_q - 9'd1;
            state_d = (cnt_q == 9'd1) ? S_CHECK : S_DATA;
         end
      end

      edit_d   = (state_d != S_IDLE) && (state_d != S_LEN);
      send_d   = (state_d == S_SEND);
      rstrom_d = (state_d == S_CLEAR);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         cnt_q      <= '0;
         unit_q     <= BASE;
         code_q     <= 8'h00;
         sum_q      <= 8'h00;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         edit_q     <= 1'b0;
         send_q     <= 1'b0;
         rstrom_q   <= 1'b0;
         busy_q     <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         cnt_q      <= cnt_d;
         unit_q     <= unit_d;
         code_q     <= code_d;
         sum_q      <= sum_d;
         done_q     <= done_d;
         err_q      <= err_d;
         edit_q     <= edit_d;
         send_q     <= send_d;
         rstrom_q   <= rstrom_d;
         busy_q     <= busy_d;
         ready_en_q <= 1'b1;
      end
   end

   assign edit   = edit_q;
   assign unit   = unit_q;
   assign code   = code_q;
   assign send   = send_q;
   assign rstROM = rstrom_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: the driver queues expected ROM writes and frame
// results, a negedge monitor pops them as send strobes, done and err appear.
module tb_rom_loader;
   localparam int SETUP = 2;
   localparam int SENDW = 4;
   localparam int CLRW  = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       abort = 1'b0;
   logic       edit;
   logic [7:0] unit;
   logic [7:0] code;
   logic       send;
   logic       rstROM;
   logic       busy;
   logic       done;
   logic       err;

   rom_loader #(.BASE(8'h00), .SETUP_CYCLES(SETUP), .SEND_CYCLES(SENDW), .CLR_CYCLES(CLRW)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .abort(abort), .edit(edit), .unit(unit), .code(code), .send(send),
      .rstROM(rstROM), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] u; logic [7:0] c; } wr_t;
   wr_t exp_wr[$];
   int  exp_res[$];            // 1 = done expected, 2 = err expected

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_acc = 0;
   int n_acc = 0;
   int n_put = 0;
   bit abort_flag = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Accept bookkeeping sampled at the active edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst && in_valid && in_ready) begin
         last_acc = cyc;
         n_acc++;
      end
   end

   // Monitor
   logic       send_p = 1'b0, rst_p = 1'b0, err_p = 1'b0;
   int         send_w = 0, clr_w = 0;
   logic [7:0] lu, lc;
   always @(negedge clk) begin
      if (send && !send_p) begin
         chk("send_rise_latency", cyc - last_acc, SETUP);
         if (exp_wr.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            wr_t w;
            w = exp_wr.pop_front();
            $display("write unit=%02h code=%02h (expect %02h/%02h)", unit, code, w.u, w.c);
            chk("write_unit", int'(unit), int'(w.u));
            chk("write_code", int'(code), int'(w.c));
         end
         lu = unit;
         lc = code;
         send_w = 0;
      end
      if (send) begin
         send_w++;
         chk("ready_low_in_send", int'(in_ready), 0);
         chk("unit_stable", int'(unit), int'(lu));
         chk("code_stable", int'(code), int'(lc));
      end
      if (!send && send_p) begin
         if (abort_flag) abort_flag = 1'b0;
         else            chk("send_width", send_w, SENDW);
      end
      if (rstROM) clr_w++;
      if (!rstROM && rst_p) begin
         chk("rstrom_width", clr_w, CLRW);
         clr_w = 0;
      end
      if (send || rstROM) chk("edit_during_write", int'(edit), 1);
      if (done) begin
         if (exp_res.size() == 0) chk("unexpected_done", 1, 0);
         else                     chk("result_done", exp_res.pop_front(), 1);
      end
      if (err && !err_p) begin
         if (exp_res.size() == 0) chk("unexpected_err", 1, 0);
         else                     chk("result_err", exp_res.pop_front(), 2);
      end
      send_p = send;
      rst_p  = rstROM;
      err_p  = err;
   end

   task automatic put(input logic [7:0] b);
      int   n;
      logic acc;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      n_put++;
      forever begin
         acc = in_ready;
         @(posedge clk);
         if (acc) break;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 0, 1);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wr(input logic [7:0] u, input logic [7:0] b);
      wr_t w;
      w.u = u;
      w.c = b;
      exp_wr.push_back(w);
      put(b);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      time t0, t1, t2;
      int  n;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_edit", int'(edit), 0);
      chk("rst_send", int'(send), 0);
      chk("rst_rstrom", int'(rstROM), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_unit", int'(unit), 0);
      chk("rst_code", int'(code), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", int'(in_ready), 1);

      // Basic 3-byte frame
      put(8'hA5);
      put(8'h03);
      wr(8'h00, 8'h10);
      wr(8'h01, 8'h20);
      wr(8'h02, 8'h30);
      exp_res.push_back(1);
      put(8'h60);
      idle();
      chk("t1_edit_after_check", int'(edit), 0);
      chk("t1_done", int'(done), 1);
      chk("t1_err", int'(err), 0);
      @(negedge clk);
      chk("t1_done_one_cycle", int'(done), 0);

      // Bad checksum, then header clears err
      put(8'hA5);
      put(8'h02);
      wr(8'h00, 8'h01);
      wr(8'h01, 8'h02);
      exp_res.push_back(2);
      put(8'h00);
      idle();
      chk("t2_err_set", int'(err), 1);
      chk("t2_no_done", int'(done), 0);
      put(8'hA5);
      idle();
      chk("t2_err_cleared", int'(err), 0);
      put(8'h01);
      wr(8'h00, 8'h05);
      exp_res.push_back(1);
      put(8'h05);
      idle();

      // Leading garbage
      put(8'h00); idle(); chk("t3_edit_g0", int'(edit), 0); chk("t3_busy_g0", int'(busy), 0);
      put(8'hFF); idle(); chk("t3_edit_g1", int'(edit), 0);
      put(8'h5A); idle(); chk("t3_edit_g2", int'(edit), 0);
      put(8'hA5);
      idle();
      chk("t3_edit_in_len", int'(edit), 0);
      chk("t3_busy_in_len", int'(busy), 1);
      put(8'h01);
      wr(8'h00, 8'h7E);
      exp_res.push_back(1);
      put(8'h7E);
      idle();

      // 256-byte frame, data includes A5
      put(8'hA5);
      put(8'h00);
      for (int i = 0; i < 256; i++) wr(8'(i), 8'(i));
      exp_res.push_back(1);
      put(8'h80);
      idle();
      chk("t4_unit_wrapped", int'(unit), 0);
      chk("t4_err", int'(err), 0);

      // Abort during the second send pulse
      put(8'hA5);
      put(8'h03);
      wr(8'h00, 8'h11);
      wr(8'h01, 8'h22);
      idle();
      n = 0;
      while (!send && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t5_send_seen", int'(send), 1);
      abort = 1'b1;
      abort_flag = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t5_send_dropped", int'(send), 0);
      chk("t5_edit_dropped", int'(edit), 0);
      chk("t5_busy_dropped", int'(busy), 0);
      chk("t5_ready_back", int'(in_ready), 1);
      repeat (3) @(negedge clk);
      chk("t5_no_done", int'(done), 0);
      put(8'hA5);
      put(8'h02);
      wr(8'h00, 8'hAA);
      wr(8'h01, 8'hBB);
      exp_res.push_back(1);
      put(8'h65);
      idle();

      // in_valid held high: data accept spacing set by setup/send/hold
      put(8'hA5);
      put(8'h03);
      wr(8'h00, 8'h01); t0 = $time;
      wr(8'h01, 8'h02); t1 = $time;
      wr(8'h02, 8'h03); t2 = $time;
      exp_res.push_back(1);
      put(8'h06);
      idle();
      chk("t6_spacing_a", int'((t1 - t0) / 10), 2 * SETUP + SENDW + 1);
      chk("t6_spacing_b", int'((t2 - t1) / 10), 2 * SETUP + SENDW + 1);

      repeat (20) @(negedge clk);
      chk("pending_writes", exp_wr.size(), 0);
      chk("pending_results", exp_res.size(), 0);
      chk("accept_count", n_acc, n_put);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
